// File: rtl/matrix_scroller_if.sv
// rtl/matrix_scroller_if.sv - character stream, colour controls and LED serial outputs of matrix_scroller
// Optional invert control is present only when MATRIX_SCROLLER_INVERT_EN is defined.
interface matrix_scroller_if;
  logic [3:0]  char_code;
  logic        char_valid;
  logic        char_ready;
  logic        pause;
  logic [31:0] fg_colour;
  logic [31:0] bg_colour;
  logic        led_clk;
  logic        led_data;
  logic        frame_sync;
`ifdef MATRIX_SCROLLER_INVERT_EN
  logic        invert;

  modport master (
    output char_code, char_valid, pause, fg_colour, bg_colour, invert,
    input  char_ready, led_clk, led_data, frame_sync
  );
  modport slave (
    input  char_code, char_valid, pause, fg_colour, bg_colour, invert,
    output char_ready, led_clk, led_data, frame_sync
  );
`else
  modport master (
    output char_code, char_valid, pause, fg_colour, bg_colour,
    input  char_ready, led_clk, led_data, frame_sync
  );
  modport slave (
    input  char_code, char_valid, pause, fg_colour, bg_colour,
    output char_ready, led_clk, led_data, frame_sync
  );
`endif
endinterface

// File: rtl/matrix_scroller.sv
// rtl/matrix_scroller.sv - 8-row LED matrix text scroller with glyph FIFO and serial frame output
// Build option MATRIX_SCROLLER_INVERT_EN adds a per-frame fg/bg swap input.
module matrix_scroller #(
  parameter int COLS       = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int FRAME_HOLD = 1,
  parameter int SERPENTINE = 1
) (
  input logic              clk,
  input logic              reset,
  matrix_scroller_if.slave bus
);

  localparam int KW = $clog2(COLS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] BLANK = 4'hF;

  typedef enum logic [1:0] {S_START, S_PIXELS, S_END} state_t;

  state_t          state;
  logic            phase;
  logic [5:0]      bcnt;
  logic [KW-1:0]   kcnt;
  logic [2:0]      rcnt;
  logic [31:0]     fg_q;
  logic [31:0]     bg_q;
  logic [COLS-1:0] bitmap [8];
  logic [3:0]      glyph_q;
  logic [2:0]      col_idx;
  logic [7:0]      frame_cnt;
  logic [3:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     level;
`ifdef MATRIX_SCROLLER_INVERT_EN
  logic            inv_q;
`endif

  function automatic logic glyph_bit(input logic [3:0] code, input logic [2:0] row,
                                     input logic [2:0] col);
    logic [63:0] g;
    case (code)
      4'd0:    g = 64'h7CC6_CEDE_F6E6_7C00;
      4'd1:    g = 64'h3070_3030_3030_FC00;
      4'd2:    g = 64'h78CC_0C38_60CC_FC00;
      4'd3:    g = 64'h78CC_0C38_0CCC_7800;
      4'd4:    g = 64'h1C3C_6CCC_FE0C_1E00;
      4'd5:    g = 64'hFCC0_F80C_0CCC_7800;
      4'd6:    g = 64'h3860_C0F8_CCCC_7800;
      4'd7:    g = 64'hFCCC_0C18_3030_3000;
      4'd8:    g = 64'h78CC_CC78_CCCC_7800;
      4'd9:    g = 64'h78CC_CC7C_0C18_7000;
      default: g = 64'h0;
    endcase
    // Row 0 is the top byte; glyph column 0 is the byte MSB.
    return g[{~row, ~col}];
  endfunction

  logic            at_sync;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            frame_done;
  logic            hold_hit;
  logic            step;
  logic            load;
  logic            pop;
  logic [3:0]      in_code;
  logic [7:0]      insert_col;
  logic [KW-1:0]   col_sel;
  logic            lit;
  logic [31:0]     word;

  assign at_sync    = (state == S_START) && (bcnt == 6'd0) && !phase;
  assign fifo_full  = (level == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (level == '0);
  assign push       = bus.char_valid && !fifo_full;
  assign frame_done = (state == S_END) && (bcnt == 6'd63) && phase;
  assign hold_hit   = frame_done && (frame_cnt == 8'(FRAME_HOLD - 1));
  assign step       = hold_hit && !bus.pause;
  assign load       = step && (col_idx == 3'd0);
  assign pop        = load && !fifo_empty;
  assign in_code    = load ? (fifo_empty ? BLANK : fifo_mem[rd_ptr]) : glyph_q;

  always_comb begin
    insert_col = '0;
    for (int r = 0; r < 8; r++) begin
      insert_col[r] = glyph_bit(in_code, 3'(r), col_idx);
    end
  end

  assign col_sel = ((SERPENTINE != 0) && !rcnt[0]) ? (KW'(COLS - 1) - kcnt) : kcnt;
`ifdef MATRIX_SCROLLER_INVERT_EN
  assign lit = bitmap[rcnt][col_sel] ^ inv_q;
`else
  assign lit = bitmap[rcnt][col_sel];
`endif
  assign word = lit ? fg_q : bg_q;

  assign bus.led_clk    = phase && !reset;
  assign bus.led_data   = (state == S_PIXELS) && word[~bcnt[4:0]] && !reset;
  assign bus.frame_sync = at_sync && !reset;
  assign bus.char_ready = !fifo_full && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_START;
      phase     <= 1'b0;
      bcnt      <= '0;
      kcnt      <= '0;
      rcnt      <= '0;
      fg_q      <= '0;
      bg_q      <= '0;
      glyph_q   <= BLANK;
      col_idx   <= '0;
      frame_cnt <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      for (int r = 0; r < 8; r++) bitmap[r] <= '0;
`ifdef MATRIX_SCROLLER_INVERT_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      phase <= !phase;
      if (at_sync) begin
        fg_q <= bus.fg_colour;
        bg_q <= bus.bg_colour;
`ifdef MATRIX_SCROLLER_INVERT_EN
        inv_q <= bus.invert;
`endif
      end
      if (phase) begin
        case (state)
          S_START: begin
            if (bcnt == 6'd31) begin
              state <= S_PIXELS;
              bcnt  <= '0;
            end else begin
              bcnt <= bcnt + 6'd1;
            end
          end
          S_PIXELS: begin
            if (bcnt == 6'd31) begin
              bcnt <= '0;
              if (kcnt == KW'(COLS - 1)) begin
                kcnt <= '0;
                if (rcnt == 3'd7) begin
                  rcnt  <= '0;
                  state <= S_END;
                end else begin
                  rcnt <= rcnt + 3'd1;
                end
              end else begin
                kcnt <= kcnt + KW'(1);
              end
            end else begin
              bcnt <= bcnt + 6'd1;
            end
          end
          S_END: begin
            if (bcnt == 6'd63) begin
              state <= S_START;
              bcnt  <= '0;
            end else begin
              bcnt <= bcnt + 6'd1;
            end
          end
          default: state <= S_START;
        endcase
      end
      if (frame_done) frame_cnt <= hold_hit ? 8'd0 : frame_cnt + 8'd1;
      // Scrolling happens only on the last END cycle, so every frame sees one bitmap.
      if (step) begin
        for (int r = 0; r < 8; r++) bitmap[r] <= {insert_col[r], bitmap[r][COLS-1:1]};
        col_idx <= col_idx + 3'd1;
        glyph_q <= in_code;
      end
      if (push) begin
        fifo_mem[wr_ptr] <= bus.char_code;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

endmodule
